spi_txn_arbiter: RTL and testbench
==================================

Name: spi_txn_arbiter

Overview:
- Shares one SPI master between NUM_REQ requesters and sequences each transfer.
- Arbitrates round-robin and captures the winner's 16-bit word and mode (CKP/CPH).
- Presents the mode to the master for a setup window, pulses transaction_stb, waits for the master's done, then returns the received word tagged with the requester id.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester id; must be >= clog2(NUM_REQ).
- SETUP_CYCLES, 2, cycles CKP/CPH/tx_data are held stable before the strobe (1..15).
- GAP_CYCLES, 4, minimum idle cycles between transactions, CS recovery (0..15).
- TIMEOUT_CYCLES, 255, cycles allowed for done before abort (used only with SPI_TIMEOUT_EN).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester request, level; held until its gnt pulse.
- req_data  in  16*NUM_REQ  packed TX words; requester i uses bits [16i+15:16i].
- req_mode  in  2*NUM_REQ  packed {CKP,CPH}; requester i uses bits [2i+1:2i].
- gnt  out  NUM_REQ  one-hot, 1-cycle pulse: request captured.
- transaction_stb  out  1  1-cycle start pulse to the SPI master.
- CKP  out  1  clock polarity to the master.
- CPH  out  1  clock phase to the master.
- tx_data  out  16  word to transmit.
- spi_done  in  1  1-cycle pulse from the master: transfer complete.
- spi_rx_data  in  16  received word; valid when spi_done=1.
- rsp_valid  out  1  1-cycle response pulse.
- rsp_id  out  ID_W  requester the response belongs to.
- rsp_data  out  16  received word.
- rsp_err  out  1  transaction aborted by timeout.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst=0): state=IDLE, rr_ptr=0.
  - Outputs on reset: gnt=0, transaction_stb=0, CKP=0, CPH=0, tx_data=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, busy=0.
  - Reset mid-transaction drops it silently; no rsp_valid is issued.
- FSM states: IDLE, SETUP, START, BUSY, DONE, GAP. State transitions only on rising clk.
- IDLE: if req!=0, pick the first set bit searching from rr_ptr upward with wrap.
  - Next cycle: gnt[w]=1; latch tx_data, CKP and CPH from slice w; latch id=w; go to SETUP.
  - rr_ptr <= (w+1) mod NUM_REQ, updated at grant.
- SETUP: hold the latched outputs for SETUP_CYCLES cycles, then go to START.
- START: transaction_stb=1 for exactly one cycle, then go to BUSY.
- BUSY: wait for spi_done=1. On done, capture spi_rx_data and go to DONE.
  - spi_done seen in any state other than BUSY is ignored.
- DONE: rsp_valid=1 for one cycle, with rsp_id=latched id, rsp_data=captured word, rsp_err=0 or 1. Go to GAP.
- GAP: count GAP_CYCLES, then go to IDLE. GAP_CYCLES=0 goes straight to IDLE.
  - Requests arriving during SETUP..GAP are held off. They are evaluated only in IDLE.
- Held outputs: CKP, CPH and tx_data keep their latched values until the next grant, so SCK idle level never glitches.
- Throughput/latency: with no contention, req rise to stb = 2+SETUP_CYCLES cycles (IDLE decision, gnt, SETUP, START). Done to rsp_valid = 1 cycle.
- Request release: dropping req before grant withdraws it. A req still high after its gnt is treated as a new request.
- Fairness: under constant requests from all NUM_REQ requesters, each is served exactly once per NUM_REQ transactions.

Optional Feature:
- Macro: SPI_TIMEOUT_EN.
- Defined:
  - BUSY runs a counter cleared at entry.
  - If it reaches TIMEOUT_CYCLES with no spi_done, go to DONE with rsp_err=1 and rsp_data=16'h0000.
  - spi_done on the same cycle as the timeout wins, giving a normal response.
- Undefined: no counter; BUSY waits indefinitely; rsp_err is tied to 0.

Test Plan:
- Single request: req=4'b0001, req_data[15:0]=16'h0407, mode=2'b01; master returns 16'hA5C3 on done.
  - Required: gnt=0001; stb 4 cycles after req; CPH=1; rsp_valid with rsp_id=0, rsp_data=16'hA5C3, rsp_err=0.
- Contention: req=4'b1111 held continuously.
  - Required: grant order 0,1,2,3,0.
  - Required: consecutive stb pulses separated by ≥ SETUP+GAP+transfer cycles.
- Wrap and skip: rr_ptr=3, req=4'b0101.
  - Required: grants go to 0, then 2.
- Mode switch: requester 1 with mode=2'b10 follows requester 0 with mode=2'b00.
  - Required: CKP rises ≥2 cycles before stb; CKP holds 1 after rsp_valid.
- Reset mid-BUSY: assert rst=0 mid-transfer.
  - Required: all outputs reset immediately.
  - Required: no rsp_valid after release; the next req is served from rr_ptr=0.
- Timeout (SPI_TIMEOUT_EN, TIMEOUT_CYCLES=10): withhold spi_done.
  - Required: rsp_valid 11 cycles after BUSY entry, with rsp_err=1, rsp_data=0.
  - Required: a late spi_done is ignored.

Source files
------------

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter and transfer sequencer sharing one SPI master between NUM_REQ requesters.
// Define SPI_TIMEOUT_EN to add a BUSY watchdog that aborts a transfer with rsp_err=1.
module spi_txn_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = 2,
  parameter int SETUP_CYCLES   = 2,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [16*NUM_REQ-1:0]   req_data,
  input  logic [2*NUM_REQ-1:0]    req_mode,
  output logic [NUM_REQ-1:0]      gnt,
  output logic                    transaction_stb,
  output logic                    CKP,
  output logic                    CPH,
  output logic [15:0]             tx_data,
  input  logic                    spi_done,
  input  logic [15:0]             spi_rx_data,
  output logic                    rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic [15:0]             rsp_data,
  output logic                    rsp_err,
  output logic                    busy
);

  // One counter serves SETUP, GAP and the BUSY watchdog, so it is sized for the largest.
  localparam int CNT_MAX = (TIMEOUT_CYCLES > 15) ? TIMEOUT_CYCLES : 15;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, SETUP, START, BUSY, DONE, GAP} state_t;

  state_t           state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  cur_id;
  logic [CNT_W-1:0] cnt;

  logic [NUM_REQ-1:0] rot;
  logic               win_found;
  int                 win_pos;
  logic [ID_W-1:0]    win_id;
  logic [ID_W-1:0]    next_ptr;
  logic [NUM_REQ-1:0] win_onehot;
  logic [15:0]        win_data;
  logic [1:0]         win_mode;

`ifdef SPI_TIMEOUT_EN
  logic err_q;
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // Rotating the doubled request vector puts rr_ptr at bit 0, so the first set bit wins.
  always_comb begin
    rot       = NUM_REQ'({req, req} >> rr_ptr);
    win_found = 1'b0;
    win_pos   = 0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!win_found && rot[j]) begin
        win_found = 1'b1;
        win_pos   = int'(rr_ptr) + j;
      end
    end
    if (win_pos >= NUM_REQ) win_pos = win_pos - NUM_REQ;
    win_id     = ID_W'(win_pos);
    next_ptr   = (win_pos == NUM_REQ - 1) ? '0 : ID_W'(win_pos + 1);
    win_onehot = '0;
    win_data   = '0;
    win_mode   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_found && win_pos == i) begin
        win_onehot[i] = 1'b1;
        win_data      = req_data[16*i +: 16];
        win_mode      = req_mode[2*i +: 2];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      cur_id          <= '0;
      cnt             <= '0;
      gnt             <= '0;
      transaction_stb <= 1'b0;
      CKP             <= 1'b0;
      CPH             <= 1'b0;
      tx_data         <= '0;
      rsp_valid       <= 1'b0;
      rsp_id          <= '0;
      rsp_data        <= '0;
      busy            <= 1'b0;
`ifdef SPI_TIMEOUT_EN
      err_q           <= 1'b0;
`endif
    end else begin
      gnt             <= '0;
      transaction_stb <= 1'b0;
      rsp_valid       <= 1'b0;
      case (state)
        // CKP/CPH/tx_data are only rewritten here, so SCK idle level holds between transfers.
        IDLE: begin
          if (win_found) begin
            gnt        <= win_onehot;
            tx_data    <= win_data;
            {CKP, CPH} <= win_mode;
            cur_id     <= win_id;
            rr_ptr     <= next_ptr;
            cnt        <= '0;
            busy       <= 1'b1;
            state      <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == CNT_W'(SETUP_CYCLES)) begin
            transaction_stb <= 1'b1;
            cnt             <= '0;
            state           <= START;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        START: state <= BUSY;
        BUSY: begin
          if (spi_done) begin
            rsp_data  <= spi_rx_data;
            rsp_id    <= cur_id;
            rsp_valid <= 1'b1;
            state     <= DONE;
`ifdef SPI_TIMEOUT_EN
            err_q     <= 1'b0;
          end else if (cnt == CNT_W'(TIMEOUT_CYCLES)) begin
            rsp_data  <= '0;
            rsp_id    <= cur_id;
            rsp_valid <= 1'b1;
            err_q     <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
`endif
          end
        end
        DONE: begin
          cnt <= '0;
          if (GAP_CYCLES == 0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            state <= GAP;
          end
        end
        GAP: begin
          if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed bench for spi_txn_arbiter: reset, contention, single request, wrap/skip,
// mode switch, reset mid-transfer and (with SPI_TIMEOUT_EN) the BUSY watchdog.
module tb_spi_txn_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [63:0] req_data = '0;
  logic [7:0]  req_mode = '0;
  logic [3:0]  gnt;
  logic        transaction_stb;
  logic        CKP;
  logic        CPH;
  logic [15:0] tx_data;
  logic        spi_done = 1'b0;
  logic [15:0] spi_rx_data = '0;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  spi_txn_arbiter #(
    .NUM_REQ(4), .ID_W(2), .SETUP_CYCLES(2), .GAP_CYCLES(4), .TIMEOUT_CYCLES(10)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_mode(req_mode),
    .gnt(gnt), .transaction_stb(transaction_stb), .CKP(CKP), .CPH(CPH),
    .tx_data(tx_data), .spi_done(spi_done), .spi_rx_data(spi_rx_data),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic set_slot(input int i, input logic [15:0] d, input logic [1:0] m);
    req_data[16*i +: 16] = d;
    req_mode[2*i +: 2]   = m;
  endtask

  task automatic wait_gnt(output logic [3:0] g, output int t);
    t = 0;
    while (gnt === 4'b0000 && t < 64) begin
      @(negedge clk);
      t++;
    end
    g = gnt;
  endtask

  task automatic wait_stb(output bit seen, output int t, output int at);
    t = 0;
    while (transaction_stb !== 1'b1 && t < 64) begin
      @(negedge clk);
      t++;
    end
    seen = (transaction_stb === 1'b1);
    at   = cyc;
  endtask

  task automatic pulse_done(input logic [15:0] rx, input int delay);
    repeat (delay) @(negedge clk);
    spi_rx_data = rx;
    spi_done    = 1'b1;
    @(negedge clk);
    spi_done    = 1'b0;
    spi_rx_data = 16'hDEAD;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy !== 1'b0 && t < 64) begin
      @(negedge clk);
      t++;
    end
    if (busy !== 1'b0) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL idle_timeout: busy=%b after %0d cycles, want 0", busy, t);
    end
  endtask

  task automatic test_reset();
    logic [43:0] outs;
    repeat (2) @(negedge clk);
    outs = {gnt, transaction_stb, CKP, CPH, tx_data, rsp_valid, rsp_id, rsp_data, rsp_err, busy};
    n_cmp++;
    if (outs !== 44'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got %h want 0", outs);
    end
    rst = 1'b1;
  endtask

  task automatic test_contention();
    logic [3:0] g;
    int t, k, at, prev;
    bit seen;
    for (int i = 0; i < 4; i++) set_slot(i, 16'h1A00 + 16'(i), 2'(i));
    req  = 4'b1111;
    prev = 0;
    for (int n = 0; n < 5; n++) begin
      int exp_id = n % 4;
      wait_gnt(g, t);
      n_cmp++;
      if (g !== 4'(1 << exp_id)) begin
        n_fail++;
        $display("[TB] FAIL contention_gnt%0d: got %b want %b", n, g, 4'(1 << exp_id));
      end
      wait_stb(seen, k, at);
      n_cmp++;
      if (!seen || tx_data !== 16'h1A00 + 16'(exp_id)) begin
        n_fail++;
        $display("[TB] FAIL contention_tx%0d: stb=%0d tx=%h want %h", n, seen, tx_data, 16'h1A00 + 16'(exp_id));
      end
      if (n > 0) begin
        n_cmp++;
        if (at - prev !== 13) begin
          n_fail++;
          $display("[TB] FAIL contention_stb_spacing%0d: got %0d want 13", n, at - prev);
        end
      end
      prev = at;
      pulse_done(16'hB000 + 16'(n), 3);
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp_id) || rsp_data !== 16'hB000 + 16'(n)) begin
        n_fail++;
        $display("[TB] FAIL contention_rsp%0d: v=%b id=%0d data=%h want 1/%0d/%h",
                 n, rsp_valid, rsp_id, rsp_data, exp_id, 16'hB000 + 16'(n));
      end
    end
    req = 4'b0000;
    wait_idle();
  endtask

  task automatic test_single();
    logic [3:0] g;
    int t, k, at;
    bit seen;
    set_slot(0, 16'h0407, 2'b01);
    @(negedge clk);
    req = 4'b0001;
    wait_gnt(g, t);
    n_cmp++;
    if (g !== 4'b0001 || t !== 1) begin
      n_fail++;
      $display("[TB] FAIL single_gnt: got %b after %0d want 0001 after 1", g, t);
    end
    req = 4'b0000;
    wait_stb(seen, k, at);
    n_cmp++;
    if (!seen || t + k !== 4) begin
      n_fail++;
      $display("[TB] FAIL single_stb_latency: got %0d want 4", t + k);
    end
    n_cmp++;
    if ({CKP, CPH} !== 2'b01 || tx_data !== 16'h0407) begin
      n_fail++;
      $display("[TB] FAIL single_mode: got %b/%h want 01/0407", {CKP, CPH}, tx_data);
    end
    pulse_done(16'hA5C3, 2);
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 16'hA5C3 || rsp_err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL single_rsp: v=%b id=%0d data=%h err=%b want 1/0/a5c3/0",
               rsp_valid, rsp_id, rsp_data, rsp_err);
    end
    wait_idle();
    n_cmp++;
    if ({CKP, CPH} !== 2'b01 || tx_data !== 16'h0407) begin
      n_fail++;
      $display("[TB] FAIL single_hold: got %b/%h want 01/0407", {CKP, CPH}, tx_data);
    end
    pulse_done(16'h1234, 0);
    n_cmp++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL idle_done_ignored: v=%b busy=%b want 0/0", rsp_valid, busy);
    end
  endtask

  task automatic test_wrap_skip();
    logic [3:0] g;
    int t, k, at;
    bit seen;
    req = 4'b0100;
    wait_gnt(g, t);
    req = 4'b0000;
    wait_stb(seen, k, at);
    pulse_done(16'h0002, 1);
    wait_idle();
    req = 4'b0101;
    wait_gnt(g, t);
    n_cmp++;
    if (g !== 4'b0001) begin
      n_fail++;
      $display("[TB] FAIL wrap_first: got %b want 0001", g);
    end
    req = 4'b0100;
    wait_stb(seen, k, at);
    pulse_done(16'h0000, 1);
    wait_gnt(g, t);
    n_cmp++;
    if (g !== 4'b0100) begin
      n_fail++;
      $display("[TB] FAIL skip_second: got %b want 0100", g);
    end
    req = 4'b0000;
    wait_stb(seen, k, at);
    pulse_done(16'h0022, 1);
    wait_idle();
  endtask

  task automatic test_mode_switch();
    logic [3:0] g;
    int t, k, at;
    bit seen;
    set_slot(0, 16'h0F0F, 2'b00);
    set_slot(1, 16'hF0F0, 2'b10);
    req = 4'b0011;
    wait_gnt(g, t);
    n_cmp++;
    if (g !== 4'b0001 || CKP !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL mode_first: gnt=%b CKP=%b want 0001/0", g, CKP);
    end
    req = 4'b0010;
    wait_stb(seen, k, at);
    pulse_done(16'h0101, 2);
    n_cmp++;
    if (CKP !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL mode_ckp_before_switch: got %b want 0", CKP);
    end
    wait_gnt(g, t);
    n_cmp++;
    if (g !== 4'b0010 || CKP !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL mode_second: gnt=%b CKP=%b want 0010/1", g, CKP);
    end
    req = 4'b0000;
    wait_stb(seen, k, at);
    n_cmp++;
    if (!seen || k !== 3 || CKP !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL mode_ckp_lead: got %0d cycles CKP=%b want 3/1", k, CKP);
    end
    pulse_done(16'h0202, 1);
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin
      n_fail++;
      $display("[TB] FAIL mode_rsp: v=%b id=%0d want 1/1", rsp_valid, rsp_id);
    end
    wait_idle();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({CKP, CPH} !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL mode_hold: got %b want 10", {CKP, CPH});
    end
  endtask

  task automatic test_reset_mid_busy();
    logic [3:0]  g;
    logic [43:0] outs;
    int t, k, at, seen_rsp;
    bit seen;
    req = 4'b0100;
    wait_gnt(g, t);
    n_cmp++;
    if (g !== 4'b0100) begin
      n_fail++;
      $display("[TB] FAIL midrst_gnt: got %b want 0100", g);
    end
    req = 4'b0000;
    wait_stb(seen, k, at);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    outs = {gnt, transaction_stb, CKP, CPH, tx_data, rsp_valid, rsp_id, rsp_data, rsp_err, busy};
    n_cmp++;
    if (outs !== 44'h0) begin
      n_fail++;
      $display("[TB] FAIL midrst_outputs: got %h want 0", outs);
    end
    @(negedge clk);
    rst = 1'b1;
    pulse_done(16'h7777, 1);
    seen_rsp = 0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid === 1'b1) seen_rsp++;
      @(negedge clk);
    end
    n_cmp++;
    if (seen_rsp !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL midrst_no_rsp: rsp pulses=%0d busy=%b want 0/0", seen_rsp, busy);
    end
    req = 4'b1010;
    wait_gnt(g, t);
    n_cmp++;
    if (g !== 4'b0010) begin
      n_fail++;
      $display("[TB] FAIL midrst_ptr: got %b want 0010", g);
    end
    req = 4'b0000;
    wait_stb(seen, k, at);
    pulse_done(16'h0303, 1);
    wait_idle();
  endtask

`ifdef SPI_TIMEOUT_EN
  task automatic test_timeout();
    logic [3:0] g;
    int t, k, at, w;
    bit seen;
    set_slot(0, 16'h5555, 2'b00);
    req = 4'b0001;
    wait_gnt(g, t);
    req = 4'b0000;
    wait_stb(seen, k, at);
    w = 0;
    while (rsp_valid !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (rsp_valid !== 1'b1 || cyc - at !== 12) begin
      n_fail++;
      $display("[TB] FAIL timeout_latency: got %0d after stb want 12", cyc - at);
    end
    n_cmp++;
    if (rsp_err !== 1'b1 || rsp_data !== 16'h0000 || rsp_id !== 2'd0) begin
      n_fail++;
      $display("[TB] FAIL timeout_rsp: err=%b data=%h id=%0d want 1/0000/0", rsp_err, rsp_data, rsp_id);
    end
    pulse_done(16'h9999, 0);
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL timeout_late_done: v=%b want 0", rsp_valid);
    end
    wait_idle();
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_wrap_skip();
    test_mode_switch();
    test_reset_mid_busy();
`ifdef SPI_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
